// File: rtl/perturbation_pkg.sv
// Shared constants and types for the OBI memory-port perturbation stages.
// Holds the stall-mode codes, the grant LFSR mask, the delay ceiling and the
// grant FSM state type used by obi_gnt_stall.
package perturbation_pkg;

  // Stall-mode codes; any other value selects "no stall".
  localparam logic [31:0] STANDARD = 32'd1;
  localparam logic [31:0] RANDOM   = 32'd2;

  // Galois feedback taps for the 16-bit grant LFSR.
  localparam logic [15:0] GNT_LFSR_MASK = 16'hB400;

  // Largest delay a stall setting can request.
  localparam int unsigned STALL_DELAY_MAX = 15;

  typedef enum logic {GNT_IDLE, GNT_WAIT} gnt_state_e;

  // Saturate a 32-bit setting at lim.
  function automatic logic [31:0] clamp_cfg(logic [31:0] val, logic [31:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/obi_stall_lfsr.sv
// Free-running 16-bit Galois LFSR used as the randomness source for stall stages.
// Advances every cycle with no enable so the sequence depends only on time since
// reset, never on traffic. SEED must be non-zero or the register locks up.
module obi_stall_lfsr
  import perturbation_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] MASK = GNT_LFSR_MASK
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Shift right and fold the taps in when the bit shifted out is set.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ MASK;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/obi_gnt_stall.sv
// Grant generator for the testbench OBI memory port.
// Delays gnt_o by a fixed or LFSR-derived number of cycles after req_i rises and
// throttles grants so in-flight transactions never exceed MAX_OUTSTANDING.
// Optional: define OBI_GNT_STALL_ASSERT_EN to compile in the protocol assertions;
// protocol_err_o works either way.
module obi_gnt_stall
  import perturbation_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned DELAY_WL        = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  output logic        gnt_o,
  input  logic        rvalid_i,
  input  logic        en_stall_i,
  input  logic [31:0] stall_mode_i,
  input  logic [31:0] max_stall_i,
  input  logic [31:0] gnt_stall_i,
  output logic [3:0]  outstanding_o,
  output logic        protocol_err_o
);

  localparam int unsigned DelayMax    = (1 << DELAY_WL) - 1;
  localparam logic [31:0] DelayMaxCfg = 32'(DelayMax);
  localparam logic [3:0]  MaxOutW     = 4'(MAX_OUTSTANDING);

  gnt_state_e          state_q, state_d;
  logic [DELAY_WL-1:0] cnt_q, cnt_d;
  logic [DELAY_WL-1:0] delay, std_delay, rand_delay;
  logic [31:0]         rand_lim;
  logic [8:0]          rand_div, rand_mod;
  logic [15:0]         lfsr;
  logic [3:0]          outstanding_q, outstanding_d;
  logic                err_q, err_d;
  logic                credit, gnt, push, pop;
  logic                unused_sig;

  obi_stall_lfsr #(
    .SEED (LFSR_SEED),
    .MASK (GNT_LFSR_MASK)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .lfsr_o (lfsr)
  );

  // Candidate delay for an IDLE evaluation; settings are sampled only here.
  always_comb begin
    std_delay  = DELAY_WL'(clamp_cfg(gnt_stall_i, DelayMaxCfg));
    rand_lim   = clamp_cfg(max_stall_i, DelayMaxCfg);
    rand_div   = 9'(rand_lim) + 9'd1;
    rand_mod   = {1'b0, lfsr[7:0]} % rand_div;
    rand_delay = rand_mod[DELAY_WL-1:0];
    delay      = '0;
    if (en_stall_i) begin
      if (stall_mode_i == STANDARD) begin
        delay = std_delay;
      end else if (stall_mode_i == RANDOM) begin
        delay = rand_delay;
      end
    end
  end

  assign credit = (outstanding_q < MaxOutW);

  // Grant FSM: next state, countdown and combinational grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    gnt     = 1'b0;
    case (state_q)
      GNT_IDLE: begin
        if (req_i) begin
          if ((delay == '0) && credit) begin
            gnt = 1'b1;
          end else begin
            // A zero delay blocked only by credit waits with an empty countdown.
            state_d = GNT_WAIT;
            cnt_d   = (delay == '0) ? '0 : delay - DELAY_WL'(1);
          end
        end
      end
      GNT_WAIT: begin
        if (!req_i) begin
          // Request withdrawn before its grant: flag it and abandon the wait.
          err_d   = 1'b1;
          state_d = GNT_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DELAY_WL'(1);
        end else if (credit) begin
          gnt     = 1'b1;
          state_d = GNT_IDLE;
        end
      end
      default: begin
        state_d = GNT_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // In-flight tracking; a simultaneous push and pop cancel out.
  always_comb begin
    push          = gnt && req_i;
    pop           = rvalid_i && (outstanding_q != 4'd0);
    outstanding_d = outstanding_q;
    if (push && !pop) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (pop && !push) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  // State, countdown, in-flight count and sticky error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= GNT_IDLE;
      cnt_q         <= '0;
      outstanding_q <= 4'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign gnt_o          = gnt;
  assign outstanding_o  = outstanding_q;
  assign protocol_err_o = err_q;

  // we_i only matters to the optional checks; the high LFSR bits are spare.
  assign unused_sig = ^{we_i, lfsr[15:8], rand_mod[8:DELAY_WL]};

`ifdef OBI_GNT_STALL_ASSERT_EN
  // A pending request must hold req_i and we_i until granted.
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_i && !gnt_o) |=> (req_i && $stable(we_i)))
    else $error("obi_gnt_stall: req_i/we_i changed before grant");

  a_gnt_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    gnt_o |-> req_i)
    else $error("obi_gnt_stall: gnt_o without req_i");

  a_out_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding_o <= MaxOutW)
    else $error("obi_gnt_stall: outstanding above limit");

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_i |-> (outstanding_o != 4'd0))
    else $error("obi_gnt_stall: rvalid_i with nothing outstanding");
`else
  // Checks compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_obi_gnt_stall.sv
// Self-checking bench for obi_gnt_stall: directed scenarios plus randomized
// request streams checked against a cycle-index model of the delay rules.
module tb_obi_gnt_stall;
  import perturbation_pkg::*;

  localparam int SeqLen = 40000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic        en_stall_i = 1'b0;
  logic [31:0] stall_mode_i = '0;
  logic [31:0] max_stall_i = '0;
  logic [31:0] gnt_stall_i = '0;
  logic        gnt_o;
  logic [3:0]  outstanding_o;
  logic        protocol_err_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;
  logic [15:0] seq [SeqLen];
  int rand_delays [1000];

  always #5 clk_i = ~clk_i;

  // Cycles since reset release; the LFSR value in cycle n is seq[n].
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cyc <= 0;
    else cyc <= cyc + 1;
  end

  obi_gnt_stall #(
    .MAX_OUTSTANDING (8),
    .DELAY_WL        (4),
    .LFSR_SEED       (16'hACE1)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .we_i           (we_i),
    .gnt_o          (gnt_o),
    .rvalid_i       (rvalid_i),
    .en_stall_i     (en_stall_i),
    .stall_mode_i   (stall_mode_i),
    .max_stall_i    (max_stall_i),
    .gnt_stall_i    (gnt_stall_i),
    .outstanding_o  (outstanding_o),
    .protocol_err_o (protocol_err_o)
  );

  task automatic step_in(input logic req, input logic rv);
    @(negedge clk_i);
    req_i = req;
    rvalid_i = rv;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_i = 1'b0;
    rvalid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Holds req_i until a grant; returns cycles from request to grant, -1 on timeout.
  task automatic measure_delay(output int d);
    d = -1;
    for (int t = 0; t < 40; t++) begin
      step_in(1'b1, 1'b0);
      if (gnt_o) begin
        d = t;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    en_stall_i = 1'b1;
    stall_mode_i = STANDARD;
    gnt_stall_i = 32'd5;
    #1;
    n_checks++;
    if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", gnt_o); end
    n_checks++;
    if (outstanding_o !== 4'd0) begin
      n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding_o);
    end
    n_checks++;
    if (protocol_err_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b expected 0", protocol_err_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step_in(1'b0, 1'b1);
    step_in(1'b0, 1'b0);
    n_checks++;
    if (outstanding_o !== 4'd0) begin
      n_fail++; $display("FAIL rvalid_at_zero: got %0d expected 0", outstanding_o);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    en_stall_i = 1'b0;
    we_i = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      step_in(1'b1, 1'b0);
      n_checks++;
      if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL no_stall_gnt[%0d]: got %b expected 1", i, gnt_o); end
      n_checks++;
      if (outstanding_o !== 4'(i)) begin
        n_fail++; $display("FAIL no_stall_out[%0d]: got %0d expected %0d", i, outstanding_o, i);
      end
    end
    step_in(1'b0, 1'b0);
    n_checks++;
    if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL gnt_without_req: got %b expected 0", gnt_o); end
    n_checks++;
    if (outstanding_o !== 4'd4) begin
      n_fail++; $display("FAIL no_stall_out4: got %0d expected 4", outstanding_o);
    end
    repeat (4) step_in(1'b0, 1'b1);
    step_in(1'b0, 1'b0);
    n_checks++;
    if (outstanding_o !== 4'd0) begin
      n_fail++; $display("FAIL drain: got %0d expected 0", outstanding_o);
    end
  endtask

  task automatic test_standard_delay();
    int d;
    int v;
    int exp_d;
    do_reset();
    en_stall_i = 1'b1;
    stall_mode_i = STANDARD;
    gnt_stall_i = 32'd3;
    for (int t = 0; t < 4; t++) begin
      step_in(1'b1, 1'b0);
      n_checks++;
      if (gnt_o !== (t == 3)) begin
        n_fail++; $display("FAIL std3_t%0d: got %b expected %b", t, gnt_o, (t == 3));
      end
    end
    step_in(1'b0, 1'b0);
    n_checks++;
    if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL std3_after: got %b expected 0", gnt_o); end
    step_in(1'b0, 1'b1);
    // Random fixed delays, including values that must clamp at 15.
    for (int k = 0; k < 8; k++) begin
      v = (k == 0) ? 100 : int'($urandom_range(0, 30));
      gnt_stall_i = 32'(v);
      exp_d = (v > 15) ? 15 : v;
      measure_delay(d);
      n_checks++;
      if (d != exp_d) begin
        n_fail++; $display("FAIL std_delay setting=%0d: got %0d expected %0d", v, d, exp_d);
      end
      step_in(1'b0, 1'b1);
    end
    // Unknown mode means no stall.
    stall_mode_i = 32'd7;
    gnt_stall_i = 32'd9;
    measure_delay(d);
    n_checks++;
    if (d != 0) begin n_fail++; $display("FAIL unknown_mode: got %0d expected 0", d); end
    step_in(1'b0, 1'b1);
  endtask

  task automatic test_credit();
    do_reset();
    en_stall_i = 1'b0;
    for (int t = 0; t < 12; t++) begin
      step_in(1'b1, 1'b0);
      n_checks++;
      if (gnt_o !== (t < 8)) begin
        n_fail++; $display("FAIL credit_t%0d: got %b expected %b", t, gnt_o, (t < 8));
      end
    end
    n_checks++;
    if (outstanding_o !== 4'd8) begin
      n_fail++; $display("FAIL credit_full: got %0d expected 8", outstanding_o);
    end
    step_in(1'b1, 1'b1);
    n_checks++;
    if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL credit_rvalid_cycle: got %b expected 0", gnt_o); end
    step_in(1'b1, 1'b0);
    n_checks++;
    if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL credit_return: got %b expected 1", gnt_o); end
    step_in(1'b1, 1'b0);
    n_checks++;
    if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL credit_refull: got %b expected 0", gnt_o); end
    n_checks++;
    if (outstanding_o !== 4'd8) begin
      n_fail++; $display("FAIL credit_out8: got %0d expected 8", outstanding_o);
    end
  endtask

  // mode 0: record delays, 1: compare with recorded, 2: model only.
  task automatic random_pass(input int n, input int mode);
    int eval_c;
    int k;
    int d;
    int lim;
    int exp_d;
    logic prev_g;
    lim = (max_stall_i > 32'd15) ? 15 : int'(max_stall_i);
    eval_c = -1;
    k = 0;
    prev_g = 1'b0;
    while (k < n) begin
      @(negedge clk_i);
      req_i = 1'b1;
      rvalid_i = prev_g;
      #1;
      if (eval_c < 0) eval_c = cyc;
      prev_g = gnt_o;
      if (gnt_o) begin
        d = cyc - eval_c;
        exp_d = int'(seq[eval_c][7:0]) % (lim + 1);
        n_checks++;
        if (d != exp_d) begin
          n_fail++; $display("FAIL rand_delay[%0d]: got %0d expected %0d", k, d, exp_d);
        end
        n_checks++;
        if (d > 15) begin n_fail++; $display("FAIL rand_range[%0d]: got %0d expected <=15", k, d); end
        if (mode == 0) rand_delays[k] = d;
        if (mode == 1) begin
          n_checks++;
          if (d != rand_delays[k]) begin
            n_fail++; $display("FAIL rand_repro[%0d]: got %0d expected %0d", k, d, rand_delays[k]);
          end
        end
        k++;
        eval_c = cyc + 1;
      end else if ((cyc - eval_c > 20) || (eval_c >= SeqLen - 1)) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_timeout[%0d]: got no grant after %0d cycles expected <=15", k, cyc - eval_c);
        break;
      end
    end
    step_in(1'b0, prev_g);
  endtask

  task automatic test_random();
    do_reset();
    en_stall_i = 1'b1;
    stall_mode_i = RANDOM;
    max_stall_i = 32'd40;
    random_pass(1000, 0);
    do_reset();
    random_pass(50, 1);
    do_reset();
    max_stall_i = 32'd3;
    random_pass(100, 2);
  endtask

  task automatic test_protocol_err();
    do_reset();
    en_stall_i = 1'b1;
    stall_mode_i = STANDARD;
    gnt_stall_i = 32'd5;
    step_in(1'b1, 1'b0);
    step_in(1'b1, 1'b0);
    step_in(1'b0, 1'b0);
    n_checks++;
    if (protocol_err_o !== 1'b0) begin
      n_fail++; $display("FAIL err_early: got %b expected 0", protocol_err_o);
    end
    en_stall_i = 1'b0;
    step_in(1'b1, 1'b0);
    n_checks++;
    if (protocol_err_o !== 1'b1) begin
      n_fail++; $display("FAIL err_set: got %b expected 1", protocol_err_o);
    end
    n_checks++;
    if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL err_back_idle: got %b expected 1", gnt_o); end
    step_in(1'b0, 1'b0);
    step_in(1'b0, 1'b1);
    n_checks++;
    if (protocol_err_o !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b expected 1", protocol_err_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    en_stall_i = 1'b0;
    step_in(1'b1, 1'b0);
    step_in(1'b0, 1'b0);
    en_stall_i = 1'b1;
    stall_mode_i = STANDARD;
    gnt_stall_i = 32'd5;
    step_in(1'b1, 1'b0);
    step_in(1'b1, 1'b0);
    step_in(1'b1, 1'b0);
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt: got %b expected 0", gnt_o); end
    n_checks++;
    if (outstanding_o !== 4'd0) begin
      n_fail++; $display("FAIL midrst_out: got %0d expected 0", outstanding_o);
    end
    n_checks++;
    if (protocol_err_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_err: got %b expected 0", protocol_err_o);
    end
    req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int t = 0; t < 6; t++) begin
      step_in(1'b1, 1'b0);
      n_checks++;
      if (gnt_o !== (t == 5)) begin
        n_fail++; $display("FAIL postrst_t%0d: got %b expected %b", t, gnt_o, (t == 5));
      end
    end
    step_in(1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    do_reset();
    en_stall_i = 1'b0;
    repeat (3) step_in(1'b1, 1'b0);
    step_in(1'b1, 1'b1);
    n_checks++;
    if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL simul_gnt: got %b expected 1", gnt_o); end
    step_in(1'b0, 1'b0);
    n_checks++;
    if (outstanding_o !== 4'd3) begin
      n_fail++; $display("FAIL simul_out: got %0d expected 3", outstanding_o);
    end
    step_in(1'b0, 1'b1);
    step_in(1'b0, 1'b0);
    n_checks++;
    if (outstanding_o !== 4'd2) begin
      n_fail++; $display("FAIL simul_pop: got %0d expected 2", outstanding_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    en_stall_i = 1'b1;
    stall_mode_i = STANDARD;
    gnt_stall_i = 32'd2;
    for (int t = 0; t < 9; t++) begin
      step_in(1'b1, 1'b0);
      n_checks++;
      if (gnt_o !== ((t % 3) == 2)) begin
        n_fail++; $display("FAIL b2b_t%0d: got %b expected %b", t, gnt_o, ((t % 3) == 2));
      end
    end
    step_in(1'b0, 1'b0);
    gnt_stall_i = 32'd4;
    // A delay-setting change mid-countdown must not reload the active wait.
    for (int t = 0; t < 6; t++) begin
      @(negedge clk_i);
      if (t == 1) gnt_stall_i = 32'd0;
      req_i = 1'b1;
      rvalid_i = (t == 0);
      #1;
      n_checks++;
      if (gnt_o !== ((t == 4) || (t == 5))) begin
        n_fail++; $display("FAIL cfg_change_t%0d: got %b expected %b", t, gnt_o, ((t == 4) || (t == 5)));
      end
    end
    step_in(1'b0, 1'b0);
  endtask

  initial begin
    seq[0] = 16'hACE1;
    for (int i = 1; i < SeqLen; i++) begin
      seq[i] = (seq[i-1] >> 1) ^ (seq[i-1][0] ? 16'hB400 : 16'h0000);
    end
    test_reset();
    test_no_stall();
    test_standard_delay();
    test_credit();
    test_random();
    test_protocol_err();
    test_reset_mid_wait();
    test_simultaneous();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
